// File: rtl/ripple_add_pkg.sv
// ripple_add_pkg: shared FSM state encoding and default sizing for the
// ripple-carry adder sequencer.
package ripple_add_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH         = 64;
    localparam int          DEF_SETTLE_CYCLES = 2;

endpackage

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: holds operands on an external combinational ripple adder
// for SETTLE_CYCLES clocks, then registers the sum. `ACCUM_EN adds in_acc (running total).
module ripple_add_sequencer
    import ripple_add_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int          SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef ACCUM_EN
    input  logic             in_acc,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1) begin : g_settle_check
        $error("ripple_add_sequencer: SETTLE_CYCLES must be >= 1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   next_a;

`ifdef ACCUM_EN
    // Running total drops the carry bit of the previous result.
    assign next_a = in_acc ? out_sum[WIDTH-1:0] : in_a;
`else
    assign next_a = in_a;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            add_a     <= '0;
            add_b     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        add_a <= next_a;
                        add_b <= in_b;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        out_sum   <= add_sum;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// tb_ripple_add_sequencer: randomized and directed checks of the sequencer against
// a transaction-level model; the adder is modelled with SETTLE_CYCLES-1 cycles of delay.
module tb_ripple_add_sequencer;

    localparam int unsigned W  = 64;
    localparam int          SC = 2;
`ifdef ACCUM_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
`ifdef ACCUM_EN
    logic         in_acc;
`endif
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W:0]   add_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic         busy;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    logic [W-1:0] prev_result;

    always #5 clk = ~clk;

    ripple_add_sequencer #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef ACCUM_EN
        .in_acc    (in_acc),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    // Slow adder: the true sum only appears SC-1 clocks after the operands.
    logic [W:0] sum_pipe [SC];
    always @(posedge clk) begin
        sum_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int i = 1; i < SC; i++) sum_pipe[i] <= sum_pipe[i-1];
    end
    assign add_sum = (SC == 1) ? ({1'b0, add_a} + {1'b0, add_b}) : sum_pipe[(SC > 1) ? SC-2 : 0];

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction from the IDLE side; called on a negedge, returns on a negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input int unsigned stall);
        logic [W-1:0] opa;
        logic [W:0]   exp;
        opa = (acc && ACC_ON) ? prev_result : a;
        exp = {1'b0, opa} + {1'b0, b};
        check("in_ready_idle", in_ready, 1);
        check("busy_idle", busy, 0);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
`ifdef ACCUM_EN
        in_acc    = acc;
`endif
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        check("add_a", add_a, opa);
        check("add_b", add_b, b);
        for (int k = 0; k < SC; k++) begin
            check("early_valid", out_valid, 0);
            check("busy_settle", busy, 1);
            check("in_ready_settle", in_ready, 0);
            check("add_a_stable", add_a, opa);
            @(negedge clk);
        end
        check("valid_rise", out_valid, 1);
        check("out_sum", out_sum, exp);
        for (int s = 0; s < int'(stall); s++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, exp);
            check("hold_in_ready", in_ready, 0);
            check("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        prev_result = exp[W-1:0];
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
`ifdef ACCUM_EN
        in_acc    = 1'b0;
`endif
        out_ready = 1'b1;
        prev_result = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Idle with no request: nothing should move.
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 1);
            check("idle_out_valid", out_valid, 0);
        end

        run_op(64'd5, 64'd8, 1'b0, 0);
        run_op('1, '1, 1'b0, 0);
        check("carry_out", out_sum, 65'h1_FFFF_FFFF_FFFF_FFFE);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 10);
        run_op('0, '0, 1'b0, 0);

        // Reset one cycle into SETTLE: the operation must vanish.
        in_valid = 1'b1;
        in_a     = 64'hDEAD_BEEF;
        in_b     = 64'h1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_add_a", add_a, 0);
        check("midrst_add_b", add_b, 0);
        prev_result = '0;
        for (int k = 0; k < SC + 2; k++) begin
            @(negedge clk);
            check("midrst_no_valid", out_valid, 0);
            check("midrst_busy", busy, 0);
        end

`ifdef ACCUM_EN
        run_op(64'd5, 64'd8, 1'b0, 0);
        run_op(64'hFFFF, 64'd3, 1'b1, 0);
        check("accum_total", out_sum, 65'd16);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
